// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word requests and
// drives the IF/ID register, with one architectural delay slot and a one-entry stall buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        branchEN,
    input  logic [31:0] branchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        err_timeout
);

    localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;
    localparam logic [31:0] TimeoutLast    = 32'(IMEM_TIMEOUT - 1);

    typedef enum logic [0:0] {StIssue, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] last_issued_q, last_issued_d;
    logic        retry_q, retry_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic [31:0] delay_addr_q, delay_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_word_q, buf_word_d;
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    logic        capture;
    logic        eff_pend;
    logic [31:0] eff_target;
    logic [31:0] eff_delay;
    logic        take_redirect;
    logic [31:0] next_addr;
    logic        rsp_valid;
    logic        timeout;
    logic        issue;

    // A branch captured this cycle is folded in immediately, so a delay slot that was
    // already issued (e.g. drained from the buffer) is followed directly by the target.
    always_comb begin
        capture       = branchEN & ~stall_req & valid_q & ~redir_pend_q;
        eff_pend      = redir_pend_q | capture;
        eff_target    = redir_pend_q ? redir_target_q : (branchAddr & ~32'h3);
        eff_delay     = redir_pend_q ? delay_addr_q : (pc_q + 32'd4);
        take_redirect = ~retry_q & eff_pend & (last_issued_q == eff_delay);
        if (retry_q) begin
            next_addr = last_issued_q;
        end else if (take_redirect) begin
            next_addr = eff_target;
        end else begin
            next_addr = fetch_pc_q;
        end
        rsp_valid = (state_q == StWait) & imem_rvalid;
        timeout   = (IMEM_TIMEOUT != 0) && (state_q == StWait) && !imem_rvalid
                    && (timer_q == TimeoutLast);
        issue     = rst & (state_q == StIssue) & (~buf_valid_q | ~stall_req);
    end

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        last_issued_d  = last_issued_q;
        retry_d        = retry_q;
        redir_target_d = redir_target_q;
        delay_addr_d   = delay_addr_q;
        redir_pend_d   = eff_pend & ~(issue & take_redirect);
        timer_d        = 32'd0;
        err_d          = timeout;

        unique case (state_q)
            StIssue: begin
                if (issue) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rsp_valid || timeout) begin
                    state_d = StIssue;
                end else if (IMEM_TIMEOUT != 0) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = StIssue;
        endcase

        if (issue) begin
            fetch_pc_d    = next_addr + 32'd4;
            last_issued_d = next_addr;
            retry_d       = 1'b0;
        end
        if (timeout) begin
            retry_d = 1'b1;
        end
        if (capture) begin
            redir_target_d = eff_target;
            delay_addr_d   = eff_delay;
        end
    end

    // IF/ID register and holding buffer; the buffer always drains before a direct response.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_word_d  = buf_word_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        if (!stall_req) begin
            if (buf_valid_q) begin
                pc_d        = buf_addr_q;
                inst_d      = buf_word_q;
                valid_d     = 1'b1;
                buf_valid_d = 1'b0;
            end else if (rsp_valid) begin
                pc_d    = last_issued_q;
                inst_d  = imem_rdata;
                valid_d = 1'b1;
            end else begin
                inst_d  = 32'd0;
                valid_d = 1'b0;
            end
        end else if (rsp_valid) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = last_issued_q;
            buf_word_d  = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIssue;
            fetch_pc_q     <= ResetPcAligned;
            last_issued_q  <= 32'd0;
            retry_q        <= 1'b0;
            redir_pend_q   <= 1'b0;
            redir_target_q <= 32'd0;
            delay_addr_q   <= 32'd0;
            buf_valid_q    <= 1'b0;
            buf_addr_q     <= 32'd0;
            buf_word_q     <= 32'd0;
            timer_q        <= 32'd0;
            err_q          <= 1'b0;
            pc_q           <= 32'd0;
            inst_q         <= 32'd0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            last_issued_q  <= last_issued_d;
            retry_q        <= retry_d;
            redir_pend_q   <= redir_pend_d;
            redir_target_q <= redir_target_d;
            delay_addr_q   <= delay_addr_d;
            buf_valid_q    <= buf_valid_d;
            buf_addr_q     <= buf_addr_d;
            buf_word_q     <= buf_word_d;
            timer_q        <= timer_d;
            err_q          <= err_d;
            pc_q           <= pc_d;
            inst_q         <= inst_d;
            valid_q        <= valid_d;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = next_addr;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = valid_q;
    assign err_timeout = err_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the fetch PC, issues word requests to instruction memory, and drives the IF/ID register.
- Consumes the ID stage's redirect outputs (branchEN, branchAddr) and its stall request; implements one architectural delay slot.
- Produces the pc/inst pair that ID decodes.
- Single outstanding memory request; one-entry holding buffer absorbs a response that returns while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release.
- IMEM_TIMEOUT, 255, cycles waiting for imem_rvalid before err_timeout pulses; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_req  in  1  ID hazard stall; IF/ID register holds.
- branchEN  in  1  ID redirect valid (branch/jump currently in ID).
- branchAddr  in  32  redirect target.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  32  word address; valid when imem_req=1.
- imem_rvalid  in  1  response strobe; arrives ≥1 cycle after imem_req.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- pc  out  32  IF/ID: address of inst.
- inst  out  32  IF/ID: instruction; 32'h0 (nop) when inst_valid=0.
- inst_valid  out  1  IF/ID holds a real instruction.
- err_timeout  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset, asynchronous while rst=0:
  - pc=0, inst=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, err_timeout=0.
  - fetch_pc=RESET_PC, buffer empty, redirect_pending=0, state=ISSUE, timer=0.
- FSM states:
  - ISSUE:
    - If the buffer is empty, or the IF/ID register will accept this cycle: imem_req=1, imem_addr=next_addr, go to WAIT.
    - Otherwise stay in ISSUE with imem_req=0.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid: deliver the word, then go to ISSUE.
    - Timer counts cycles in WAIT. On reaching IMEM_TIMEOUT: pulse err_timeout, reissue the same address, go to ISSUE.
- next_addr:
  - If redirect_pending and last_issued==delay_addr: next_addr=redirect_target; redirect_pending clears when imem_req fires.
  - Otherwise next_addr=fetch_pc.
  - fetch_pc takes next_addr+4 whenever imem_req fires.
- Delivery of a response:
  - If IF/ID accepts this cycle: write pc/inst/inst_valid=1 directly.
  - Else write the buffer (addr, word).
- IF/ID update, every edge with stall_req=0:
  - Source is the buffer if non-empty, else the direct response, else a bubble (inst=0, inst_valid=0, pc unchanged).
  - The buffer drains first; the buffer and a direct response never collide because only one request is outstanding.
- stall_req=1: pc/inst/inst_valid hold.
- Redirect capture, when branchEN=1, stall_req=0 and inst_valid=1:
  - redirect_target=branchAddr, delay_addr=pc+4, redirect_pending=1.
  - branchEN is ignored while stall_req=1 (ID re-presents it after the stall).
- Delay slot:
  - The instruction at delay_addr is always fetched and delivered.
  - The first address issued after it is redirect_target.
  - Sequential addresses past delay_addr are never issued while redirect_pending=1.
- Simultaneous events:
  - branchEN in the same cycle as imem_rvalid: both take effect.
  - A new branchEN while redirect_pending=1 (branch in a delay slot) is dropped.
- Arithmetic: PC increments are modulo 2^32; 32'hFFFF_FFFC wraps to 0. Low two address bits are always 0.
- Reset mid-WAIT:
  - Everything returns to reset values.
  - A late imem_rvalid after reset release is discarded until the first new request has been issued.

Test Plan:
- Reset release, imem latency 1, no stalls → imem_addr 0,4,8,C on successive requests; inst_valid rises 2 cycles after the first request; pc sequence 0,4,8.
- stall_req high 3 cycles while a response arrives → IF/ID holds its pc; the arriving word is buffered, no request is issued; after release the buffered word appears next with no loss or duplication.
- branchEN=1 with pc=0x10, branchAddr=0x40 → fetched addresses 0x10, 0x14 (delay slot), 0x40, 0x44; 0x18 is never requested.
- Memory never answers, IMEM_TIMEOUT=4 → err_timeout pulses after 4 WAIT cycles; the same address is reissued.
- RESET_PC=32'hFFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted during WAIT, then a late imem_rvalid arrives → outputs at reset values; the late word is not delivered.
